// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer: fetches the word at cur_pc and hands it downstream.
// Optional feature macro: PC_ALIGN_CHECK_EN (redirects misaligned next_pc to TRAP_PC).
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] cur_pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_count,
    output logic        misalign_err
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic            capture;
    logic            handoff;
    logic            misaligned;
    logic [XLEN-1:0] redirect_pc;

    logic [XLEN-1:0] cur_pc_nxt;
    logic [XLEN-1:0] instr_nxt;
    logic            instr_valid_nxt;
    logic            imem_req_nxt;
    logic [XLEN-1:0] instr_count_nxt;
    logic            misalign_nxt;

    // A trap target that is itself misaligned would re-trap forever
    if (TRAP_PC[1:0] != 2'b00) begin : g_trap_pc_check
        $error("TRAP_PC must be word aligned");
    end

    assign capture   = (state == FETCH) && imem_ack;
    assign handoff   = (state == VALID) && instr_ready && !stall;
    assign imem_addr = cur_pc;

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned  = (next_pc[1:0] != 2'b00);
    assign redirect_pc = misaligned ? TRAP_PC : next_pc;
`else
    assign misaligned  = 1'b0;
    assign redirect_pc = next_pc & PC_MASK;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (capture) state_nxt = VALID;
            VALID:   if (handoff) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        cur_pc_nxt      = cur_pc;
        instr_nxt       = instr;
        instr_count_nxt = instr_count;
        misalign_nxt    = 1'b0;
        imem_req_nxt    = (state_nxt == FETCH);
        instr_valid_nxt = (state_nxt == VALID);
        if (capture) begin
            instr_nxt = imem_rdata;
        end
        if (handoff) begin
            cur_pc_nxt      = redirect_pc;
            instr_count_nxt = instr_count + XLEN'(1);
            misalign_nxt    = misaligned;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_pc      <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            instr_count <= '0;
        end else begin
            cur_pc      <= cur_pc_nxt;
            instr       <= instr_nxt;
            instr_valid <= instr_valid_nxt;
            imem_req    <= imem_req_nxt;
            instr_count <= instr_count_nxt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // One-cycle pulse on a redirected handoff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= misalign_nxt;
        end
    end
`else
    logic misalign_unused;
    assign misalign_unused = misalign_nxt;
    assign misalign_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench for pc_fetch_unit: a memory responder pushes expected {pc, instr} pairs,
// a monitor pops them on each downstream handoff; directed checks cover timing and boundaries.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] cur_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_count;
    logic        misalign_err;

    // Responder / manual drive controls
    logic        auto_en;
    logic        fixed_data;
    int          ack_delay;
    int          wait_cnt;
    logic        auto_ack;
    logic [31:0] auto_data;
    logic        man_ack;
    logic [31:0] man_data;
    logic        npc_ovr;
    logic [31:0] npc_val;

    int checks;
    int errors;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_ins_q[$];

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] EXP_REDIR   = 32'h0000_0080;
    localparam logic        EXP_MISALGN = 1'b1;
`else
    localparam logic [31:0] EXP_REDIR   = 32'h0000_0040;
    localparam logic        EXP_MISALGN = 1'b0;
`endif

    pc_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .TRAP_PC (32'h0000_0080)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .next_pc     (next_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .cur_pc      (cur_pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_count (instr_count),
        .misalign_err(misalign_err)
    );

    assign next_pc    = npc_ovr ? npc_val : cur_pc + 32'd4;
    assign imem_ack   = auto_en ? auto_ack : man_ack;
    assign imem_rdata = auto_en ? auto_data : man_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks after ack_delay request cycles and records the expected handoff
    always @(negedge clk) begin
        if (auto_en && imem_req && !auto_ack) begin
            if (wait_cnt >= ack_delay) begin
                auto_ack  = 1'b1;
                auto_data = fixed_data ? 32'h2000_0001 : (imem_addr ^ 32'hDEAD_0000);
                exp_pc_q.push_back(imem_addr);
                exp_ins_q.push_back(auto_data);
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            auto_ack = 1'b0;
        end
    end

    // Monitor: every downstream handoff must match the oldest fetched word
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready && !stall) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: handoff of %h at pc %h with nothing expected", instr, cur_pc);
            end else begin
                check("sb_pc", cur_pc, exp_pc_q.pop_front());
                check("sb_instr", instr, exp_ins_q.pop_front());
            end
        end
    end

    logic [31:0] base_pc;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; stall = 1'b0; instr_ready = 1'b0;
        auto_en = 1'b0; fixed_data = 1'b1; ack_delay = 0; wait_cnt = 0;
        auto_ack = 1'b0; auto_data = '0; man_ack = 1'b0; man_data = '0;
        npc_ovr = 1'b0; npc_val = '0;

        // Reset state
        tick(); tick();
        check("rst_cur_pc", cur_pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_count", instr_count, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'h0);

        // 1: zero-wait memory, 2 cycles per instruction
        @(negedge clk);
        rst = 1'b0; auto_en = 1'b1; instr_ready = 1'b1;
        tick();
        check("t1_req0", 32'(imem_req), 32'h1);
        check("t1_addr0", imem_addr, 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k % 2 == 0) begin
                check("t1_valid", 32'(instr_valid), 32'h1);
            end else begin
                check("t1_addr", imem_addr, 32'(4 * ((k + 1) / 2)));
                check("t1_req", 32'(imem_req), 32'h1);
            end
        end
        check("t1_count", instr_count, 32'd3);

        // 2: ack delayed 3 cycles at cur_pc 0x10
        fixed_data = 1'b0;
        tick();
        ack_delay = 3;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("t2_req_hold", 32'(imem_req), 32'h1);
            check("t2_addr_hold", imem_addr, 32'h10);
            tick();
        end
        check("t2_valid_low", 32'(instr_valid), 32'h0);
        tick();
        check("t2_valid_rise", 32'(instr_valid), 32'h1);

        // 3: stall beats ready; ack outside FETCH ignored
        stall = 1'b1; ack_delay = 0;
        auto_en = 1'b0; man_ack = 1'b1; man_data = 32'hBADB_AD00;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_cur_pc", cur_pc, 32'h10);
            check("t3_instr", instr, 32'hDEAD_0010);
            check("t3_count", instr_count, 32'd4);
        end
        man_ack = 1'b0; auto_en = 1'b1;
        @(negedge clk);
        stall = 1'b0;
        tick();
        check("t3_handoff_pc", cur_pc, 32'h14);
        check("t3_handoff_count", instr_count, 32'd5);
        check("t3_handoff_valid", 32'(instr_valid), 32'h0);

        // 4: reset during FETCH with a same-cycle ack
        auto_en = 1'b0; man_ack = 1'b1; man_data = 32'h1234_5678; rst = 1'b1;
        #1;
        check("t4_cur_pc", cur_pc, 32'h0);
        check("t4_valid", 32'(instr_valid), 32'h0);
        check("t4_instr", instr, 32'h0);
        tick();
        check("t4_instr_held", instr, 32'h0);
        @(negedge clk);
        man_ack = 1'b0; rst = 1'b0;
        exp_pc_q.delete(); exp_ins_q.delete();
        auto_en = 1'b1; wait_cnt = 0;
        tick();
        check("t4_refetch_addr", imem_addr, 32'h0);
        check("t4_refetch_req", 32'(imem_req), 32'h1);

        // 5: misaligned next_pc at handoff
        npc_ovr = 1'b1; npc_val = 32'h0000_0042;
        tick();
        tick();
        check("t5_cur_pc", cur_pc, EXP_REDIR);
        check("t5_misalign", 32'(misalign_err), 32'(EXP_MISALGN));
        check("t5_count", instr_count, 32'd1);
        npc_ovr = 1'b0; instr_ready = 1'b0;
        base_pc = EXP_REDIR;
        tick();
        check("t5_misalign_pulse", 32'(misalign_err), 32'h0);

        // 6: instr_count wraps
        force dut.instr_count = 32'hFFFF_FFFF;
        tick();
        release dut.instr_count;
        check("t6_preload", instr_count, 32'hFFFF_FFFF);
        check("t6_valid", 32'(instr_valid), 32'h1);
        instr_ready = 1'b1;
        tick();
        check("t6_wrap", instr_count, 32'h0);
        check("t6_pc", cur_pc, base_pc + 32'd4);

        auto_en = 1'b0; instr_ready = 1'b0;
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
